net_config_controller: RTL

NET_CONFIG_CONTROLLER -- requirements
Module: net_config_controller

---
 rtl/net_config_controller.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/net_config_controller.sv
// Config/routing-table controller: captures a config beat and table from host or network,
// streams the table to the routing-table port, acks, and as master distributes and collects slave acks.
// Optional WAIT_ACK timeout is built in when CFG_ACK_TIMEOUT_EN is defined.
module net_config_controller #(
    parameter int TABLE_WORDS     = 4,
    parameter int DEVICE_ID_WIDTH = 10,
    parameter int ACK_TIMEOUT     = 65536
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          host_in_valid,
    input  logic                          host_in_last,
    input  logic [127:0]                  host_in_data,
    output logic                          host_in_ready,
    output logic                          host_out_valid,
    output logic                          host_out_last,
    output logic [127:0]                  host_out_data,
    input  logic                          host_out_ready,
    input  logic                          net_rx_valid,
    input  logic                          net_rx_last,
    input  logic [15:0]                   net_rx_addr,
    input  logic [127:0]                  net_rx_data,
    output logic                          net_rx_ready,
    output logic                          net_tx_valid,
    output logic                          net_tx_last,
    output logic [15:0]                   net_tx_addr,
    output logic [127:0]                  net_tx_data,
    input  logic                          net_tx_ready,
    output logic                          rt_we,
    output logic [$clog2(4*TABLE_WORDS)-1:0] rt_addr,
    output logic [31:0]                   rt_word,
    output logic [127:0]                  cfg_word,
    output logic [15:0]                   net_size,
    output logic [DEVICE_ID_WIDTH-1:0]    device_id,
    output logic [3:0]                    state,
    output logic                          programmed,
    output logic                          error
);
    localparam int AW = $clog2(4*TABLE_WORDS);
    localparam int IW = (TABLE_WORDS > 1) ? $clog2(TABLE_WORDS) : 1;
    localparam int BW = $clog2(TABLE_WORDS + 1);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_RCV_TABLE = 4'd1;
    localparam logic [3:0] ST_FILL      = 4'd2;
    localparam logic [3:0] ST_ACK_1     = 4'd3;
    localparam logic [3:0] ST_ACK_2     = 4'd4;
    localparam logic [3:0] ST_DIST      = 4'd5;
    localparam logic [3:0] ST_WAIT_ACK  = 4'd6;
    localparam logic [3:0] ST_DONE      = 4'd7;
    localparam logic [3:0] ST_ERROR     = 4'd8;

    if (TABLE_WORDS < 1) begin : g_bad_table
        $error("TABLE_WORDS must be at least 1");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    logic [3:0]    r_state;
    logic [127:0]  r_cfg_word;
    logic          r_master;
    logic          r_src_host;
    logic [15:0]   r_master_addr;
    logic [127:0]  r_table [TABLE_WORDS];
    logic [BW-1:0] r_beat_cnt;
    logic [AW-1:0] r_wcnt;
    logic [15:0]   r_ack_cnt;
    logic          r_first;
    logic [15:0]   r_dist_addr;
    logic          r_resp_pending;
    logic [127:0]  r_resp_data;

    logic [7:0]    w_nf;
    logic [BW-1:0] w_n;
    logic [AW-1:0] w_last_waddr;
    logic [127:0]  w_rd_beat;
    logic [15:0]   w_first_addr;
    logic          w_in_fire;
    logic [127:0]  w_in_data;
    logic          w_ack_fire;

    assign cfg_word   = r_cfg_word;
    assign net_size   = r_cfg_word[15:0];
    assign device_id  = r_cfg_word[16 +: DEVICE_ID_WIDTH];
    assign state      = r_state;
    assign programmed = (r_state == ST_DONE);

    // Table length clamped into 1..TABLE_WORDS.
    always_comb begin
        w_nf = r_cfg_word[103:96];
        if (w_nf == 8'd0)
            w_n = BW'(1);
        else if (32'(w_nf) > TABLE_WORDS)
            w_n = BW'(TABLE_WORDS);
        else
            w_n = BW'(w_nf);
    end

    assign w_last_waddr = AW'({w_n, 2'b00} - 1'b1);
    assign w_rd_beat    = r_table[IW'(r_wcnt >> 2)];
    assign w_first_addr = 16'({2'b00, host_in_data[16 +: DEVICE_ID_WIDTH], 4'h0});
    assign w_in_fire    = r_src_host ? (host_in_valid & host_in_ready) : (net_rx_valid & net_rx_ready);
    assign w_in_data    = r_src_host ? host_in_data : net_rx_data;
    assign w_ack_fire   = r_src_host ? (host_out_valid & host_out_ready) : (net_tx_valid & net_tx_ready);

    // Every stream holds valid/data/last steady while ready is low because all
    // outputs are decoded from registered state, except DIST which is a pure pass-through.
    always_comb begin
        host_in_ready  = 1'b0;
        net_rx_ready   = 1'b0;
        host_out_valid = 1'b0;
        host_out_last  = 1'b0;
        host_out_data  = '0;
        net_tx_valid   = 1'b0;
        net_tx_last    = 1'b0;
        net_tx_addr    = '0;
        net_tx_data    = '0;
        rt_we          = 1'b0;
        rt_addr        = r_wcnt;
        rt_word        = w_rd_beat[{r_wcnt[1:0], 5'b0} +: 32];
        case (r_state)
            ST_IDLE: begin
                host_in_ready = 1'b1;
                net_rx_ready  = 1'b1;
            end
            ST_RCV_TABLE: begin
                host_in_ready = r_src_host;
                net_rx_ready  = ~r_src_host;
            end
            ST_FILL: rt_we = 1'b1;
            ST_ACK_1, ST_ACK_2: begin
                if (r_src_host) begin
                    host_out_valid = 1'b1;
                    host_out_last  = (r_state == ST_ACK_2);
                    host_out_data  = 128'(device_id);
                end else begin
                    net_tx_valid = 1'b1;
                    net_tx_last  = (r_state == ST_ACK_2);
                    net_tx_addr  = r_master_addr;
                    net_tx_data  = 128'(device_id);
                end
            end
            ST_DIST: begin
                net_tx_valid  = host_in_valid;
                net_tx_last   = host_in_last;
                net_tx_data   = host_in_data;
                net_tx_addr   = r_first ? w_first_addr : r_dist_addr;
                host_in_ready = net_tx_ready;
            end
            ST_WAIT_ACK: begin
                net_rx_ready   = ~r_resp_pending;
                host_out_valid = r_resp_pending;
                host_out_last  = 1'b1;
                host_out_data  = r_resp_data;
            end
            ST_ERROR: begin
                host_out_valid = r_resp_pending;
                host_out_last  = 1'b1;
                host_out_data  = r_resp_data;
            end
            default: ;
        endcase
        if (!rst_n) begin
            host_in_ready = 1'b0;
            net_rx_ready  = 1'b0;
        end
    end

`ifdef CFG_ACK_TIMEOUT_EN
    logic [31:0] r_timer;
    logic        r_error;
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cfg_word     <= '0;
            r_master       <= 1'b0;
            r_src_host     <= 1'b0;
            r_master_addr  <= '0;
            r_beat_cnt     <= '0;
            r_wcnt         <= '0;
            r_ack_cnt      <= '0;
            r_first        <= 1'b0;
            r_dist_addr    <= '0;
            r_resp_pending <= 1'b0;
            r_resp_data    <= '0;
            for (int i = 0; i < TABLE_WORDS; i++) r_table[i] <= '0;
`ifdef CFG_ACK_TIMEOUT_EN
            r_timer        <= '0;
            r_error        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_beat_cnt <= '0;
                    if (host_in_valid) begin
                        r_cfg_word <= host_in_data;
                        r_master   <= host_in_data[112];
                        r_src_host <= 1'b1;
                        r_state    <= ST_RCV_TABLE;
                    end else if (net_rx_valid) begin
                        r_cfg_word    <= net_rx_data;
                        r_master      <= 1'b0;
                        r_src_host    <= 1'b0;
                        r_master_addr <= net_rx_addr;
                        r_state       <= ST_RCV_TABLE;
                    end
                end
                ST_RCV_TABLE: begin
                    if (w_in_fire) begin
                        r_table[IW'(r_beat_cnt)] <= w_in_data;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == w_n - 1'b1) begin
                            r_wcnt  <= '0;
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (r_wcnt == w_last_waddr) r_state <= ST_ACK_1;
                end
                ST_ACK_1: if (w_ack_fire) r_state <= ST_ACK_2;
                ST_ACK_2: begin
                    if (w_ack_fire) begin
                        r_ack_cnt <= 16'd1;
                        r_first   <= 1'b1;
                        r_state   <= (r_master && (net_size > 16'd1)) ? ST_DIST : ST_DONE;
                    end
                end
                ST_DIST: begin
                    if (host_in_valid && host_in_ready) begin
                        if (r_first) r_dist_addr <= w_first_addr;
                        r_first <= host_in_last;
                        if (host_in_last) begin
                            r_state <= ST_WAIT_ACK;
`ifdef CFG_ACK_TIMEOUT_EN
                            r_timer <= '0;
`endif
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (r_resp_pending) begin
                        if (host_out_ready) begin
                            r_resp_pending <= 1'b0;
                            r_state <= (r_ack_cnt == net_size) ? ST_DONE : ST_DIST;
                        end
                    end else if (net_rx_valid) begin
`ifdef CFG_ACK_TIMEOUT_EN
                        r_timer <= '0;
`endif
                        if (net_rx_last) begin
                            r_resp_pending <= 1'b1;
                            r_resp_data    <= {112'b0, net_rx_addr};
                            if (r_ack_cnt != 16'hFFFF) r_ack_cnt <= r_ack_cnt + 16'd1;
                        end
                    end
`ifdef CFG_ACK_TIMEOUT_EN
                    else if (r_timer == 32'(ACK_TIMEOUT - 1)) begin
                        r_error        <= 1'b1;
                        r_resp_pending <= 1'b1;
                        r_resp_data    <= 128'hFFFF;
                        r_state        <= ST_ERROR;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
`endif
                end
                ST_ERROR: if (r_resp_pending && host_out_ready) r_resp_pending <= 1'b0;
                ST_DONE: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
